// File: rtl/reg_file_2r1w.sv
// Edge-triggered 2-read/1-write register file with registered, write-first bypassed read ports.
// Each read port is a small sub-module instantiated once per port from a generate loop.

module rf_rd_port #(
  parameter int WIDTH   = 8,
  parameter int NREG    = 8,
  parameter int ZERO_R0 = 1,
  parameter int AW      = $clog2(NREG)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        re_i,
  input  logic [AW-1:0]               ra_i,
  input  logic                        we_i,
  input  logic [AW-1:0]               wa_i,
  input  logic [WIDTH-1:0]            wd_i,
  input  logic [NREG-1:0][WIDTH-1:0]  mem_i,
  output logic [WIDTH-1:0]            q_o,
  output logic                        v_o
);
  typedef enum logic {IDLE, VALID} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  q_q, q_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
    end
  end

  // R0 check comes first so a same-edge write to r0 never bypasses through.
  always_comb begin
    state_d = IDLE;
    q_d     = q_q;
    if (re_i) begin
      state_d = VALID;
      if (ZERO_R0 != 0 && ra_i == '0)  q_d = '0;
      else if (we_i && ra_i == wa_i)   q_d = wd_i;
      else                             q_d = mem_i[ra_i];
    end
  end

  assign q_o = q_q;
  assign v_o = (state_q == VALID);
endmodule

module reg_file_2r1w #(
  parameter int WIDTH   = 8,
  parameter int NREG    = 8,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [WIDTH-1:0]  wd_i,
  input  logic              re_a_i,
  input  logic [AW-1:0]     ra_a_i,
  input  logic              re_b_i,
  input  logic [AW-1:0]     ra_b_i,
  output logic [WIDTH-1:0]  q_a_o,
  output logic [WIDTH-1:0]  q_b_o,
  output logic              v_a_o,
  output logic              v_b_o
);
  localparam int NPORT = 2;

  logic [NREG-1:0][WIDTH-1:0]   mem_q, mem_d;
  logic [NPORT-1:0]             re, v;
  logic [NPORT-1:0][AW-1:0]     ra;
  logic [NPORT-1:0][WIDTH-1:0]  q;

  always_comb begin
    mem_d = mem_q;
    if (we_i && !(ZERO_R0 != 0 && wa_i == '0)) mem_d[wa_i] = wd_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mem_q <= '0;
    else         mem_q <= mem_d;
  end

  assign re = {re_b_i, re_a_i};
  assign ra = {ra_b_i, ra_a_i};

  for (genvar g = 0; g < NPORT; g++) begin : g_port
    rf_rd_port #(.WIDTH(WIDTH), .NREG(NREG), .ZERO_R0(ZERO_R0), .AW(AW)) u_port (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .re_i   (re[g]),
      .ra_i   (ra[g]),
      .we_i   (we_i),
      .wa_i   (wa_i),
      .wd_i   (wd_i),
      .mem_i  (mem_q),
      .q_o    (q[g]),
      .v_o    (v[g])
    );
  end

  assign q_a_o = q[0];
  assign q_b_o = q[1];
  assign v_a_o = v[0];
  assign v_b_o = v[1];
endmodule
